// File: rtl/stack_op_sequencer.sv
`default_nettype none
// ============================================================================
//  stack_op_sequencer: expands Forth stack words into T/N write-port steps.
//  Revision: 1.0
// ============================================================================
module stack_op_sequencer #(
    parameter int WIDTH   = 16,
    parameter int DEPTH   = 256,
    parameter int DEPTH_W = 9
) (
    input  logic               Clk,
    input  logic               Rst,
    input  logic               ReqValid_i,
    output logic               ReqReady_o,
    input  logic [2:0]         ReqOp_i,
    input  logic [WIDTH-1:0]   ReqData_i,
    input  logic               Clr_i,
    input  logic [WIDTH-1:0]   StkT_i,
    input  logic [WIDTH-1:0]   StkN_i,
    output logic               StkTWrite_o,
    output logic               StkNWrite_o,
    output logic [WIDTH-1:0]   StkWData_o,
    output logic [1:0]         StkOffset_o,
    output logic               StkRst_o,
    output logic               Done_o,
    output logic               Err_o,
    output logic               ErrUf_o,
    output logic               ErrOf_o,
    output logic [DEPTH_W-1:0] Depth_o
);

    localparam logic [2:0] S_IDLE  = 3'd0;
    localparam logic [2:0] S_1     = 3'd1;
    localparam logic [2:0] S_2     = 3'd2;
    localparam logic [2:0] S_3     = 3'd3;
    localparam logic [2:0] S_4     = 3'd4;
    localparam logic [2:0] S_CLEAR = 3'd5;

    localparam logic [2:0] OP_NOP  = 3'd0;
    localparam logic [2:0] OP_DUP  = 3'd1;
    localparam logic [2:0] OP_DROP = 3'd2;
    localparam logic [2:0] OP_SWAP = 3'd3;
    localparam logic [2:0] OP_OVER = 3'd4;
    localparam logic [2:0] OP_NIP  = 3'd5;
    localparam logic [2:0] OP_TUCK = 3'd6;
    localparam logic [2:0] OP_PUSH = 3'd7;

    localparam logic [1:0] OFF_NONE = 2'b00;
    localparam logic [1:0] OFF_INC  = 2'b01;
    localparam logic [1:0] OFF_DEC  = 2'b11;

    localparam logic [DEPTH_W-1:0] DEPTH_MAX = DEPTH_W'(DEPTH);

    logic [2:0]         state_q, state_d;
    logic [2:0]         op_q;
    logic [WIDTH-1:0]   a_q, b_q, lit_q;
    logic [DEPTH_W-1:0] depth_q;
    logic               err_q, nop_done_q, uf_q, of_q;

    logic w_accept, w_need1, w_need2, w_grows, w_uf, w_of, w_legal, w_last;

    assign ReqReady_o = (state_q == S_IDLE) & ~Clr_i & ~Rst;
    assign w_accept   = ReqValid_i & ReqReady_o;

    assign w_need1 = (ReqOp_i == OP_DUP) | (ReqOp_i == OP_DROP);
    assign w_need2 = (ReqOp_i == OP_SWAP) | (ReqOp_i == OP_OVER) |
                     (ReqOp_i == OP_NIP)  | (ReqOp_i == OP_TUCK);
    assign w_grows = (ReqOp_i == OP_DUP)  | (ReqOp_i == OP_OVER) |
                     (ReqOp_i == OP_TUCK) | (ReqOp_i == OP_PUSH);
    assign w_uf    = (w_need1 & (depth_q == '0)) | (w_need2 & (depth_q < DEPTH_W'(2)));
    assign w_of    = w_grows & (depth_q == DEPTH_MAX);
    assign w_legal = ~w_uf & ~w_of;

    // SWAP ends in S2, TUCK in S4; every other op is a single step
    assign w_last = ((state_q == S_1) & (op_q != OP_SWAP) & (op_q != OP_TUCK)) |
                    ((state_q == S_2) & (op_q == OP_SWAP)) |
                    (state_q == S_4);

    always_ff @(posedge Clk) begin
        if (Rst) state_q <= S_IDLE;
        else     state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        if (Clr_i) begin
            state_d = S_CLEAR;
        end else begin
            case (state_q)
                S_IDLE:  if (w_accept && w_legal && (ReqOp_i != OP_NOP)) state_d = S_1;
                S_1:     state_d = w_last ? S_IDLE : S_2;
                S_2:     state_d = w_last ? S_IDLE : S_3;
                S_3:     state_d = S_4;
                default: state_d = S_IDLE;
            endcase
        end
    end

    always_comb begin
        StkOffset_o = OFF_NONE;
        StkTWrite_o = 1'b0;
        StkNWrite_o = 1'b0;
        StkWData_o  = '0;
        case (state_q)
            S_1: begin
                case (op_q)
                    OP_DUP:  begin StkOffset_o = OFF_INC; StkTWrite_o = 1'b1; StkWData_o = b_q;   end
                    OP_DROP: begin StkOffset_o = OFF_DEC; end
                    OP_OVER: begin StkOffset_o = OFF_INC; StkTWrite_o = 1'b1; StkWData_o = a_q;   end
                    OP_NIP:  begin StkOffset_o = OFF_DEC; StkTWrite_o = 1'b1; StkWData_o = b_q;   end
                    OP_PUSH: begin StkOffset_o = OFF_INC; StkTWrite_o = 1'b1; StkWData_o = lit_q; end
                    OP_SWAP: begin StkTWrite_o = 1'b1; StkWData_o = a_q; end
                    OP_TUCK: begin StkNWrite_o = 1'b1; StkWData_o = b_q; end
                    default: ;
                endcase
            end
            S_2: begin
                if (op_q == OP_SWAP) begin
                    StkNWrite_o = 1'b1; StkWData_o = b_q;
                end else if (op_q == OP_TUCK) begin
                    StkOffset_o = OFF_INC; StkTWrite_o = 1'b1; StkWData_o = a_q;
                end
            end
            S_3:     begin StkTWrite_o = 1'b1; StkWData_o = b_q; end
            S_4:     begin StkNWrite_o = 1'b1; StkWData_o = a_q; end
            default: ;
        endcase
    end

    assign StkRst_o = (state_q == S_CLEAR);
    assign Done_o   = w_last | nop_done_q;
    assign Err_o    = err_q;
    assign ErrUf_o  = uf_q;
    assign ErrOf_o  = of_q;
    assign Depth_o  = depth_q;

    always_ff @(posedge Clk) begin
        if (Rst) begin
            op_q       <= OP_NOP;
            a_q        <= '0;
            b_q        <= '0;
            lit_q      <= '0;
            depth_q    <= '0;
            err_q      <= 1'b0;
            nop_done_q <= 1'b0;
            uf_q       <= 1'b0;
            of_q       <= 1'b0;
        end else begin
            err_q      <= 1'b0;
            nop_done_q <= 1'b0;
            if (w_accept) begin
                op_q  <= ReqOp_i;
                a_q   <= StkN_i;
                b_q   <= StkT_i;
                lit_q <= ReqData_i;
                if (w_uf) begin
                    err_q <= 1'b1;
                    uf_q  <= 1'b1;
                end else if (w_of) begin
                    err_q <= 1'b1;
                    of_q  <= 1'b1;
                end else if (ReqOp_i == OP_NOP) begin
                    nop_done_q <= 1'b1;
                end
            end
            // Depth is already zero during the CLEAR cycle itself
            if (Clr_i || (state_q == S_CLEAR))
                depth_q <= '0;
            else if ((StkOffset_o == OFF_INC) && (depth_q != DEPTH_MAX))
                depth_q <= depth_q + DEPTH_W'(1);
            else if ((StkOffset_o == OFF_DEC) && (depth_q != '0))
                depth_q <= depth_q - DEPTH_W'(1);
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_stack_op_sequencer.sv
`default_nettype none
// ============================================================================
//  tb_stack_op_sequencer: directed + randomized bench with a stack model.
//  Revision: 1.0
// ============================================================================
module tb_stack_op_sequencer;

    localparam int WIDTH   = 16;
    localparam int DEPTH   = 256;
    localparam int DEPTH_W = 9;

    logic               Clk = 1'b0;
    logic               Rst = 1'b1;
    logic               ReqValid = 1'b0;
    logic               ReqReady;
    logic [2:0]         ReqOp = 3'd0;
    logic [WIDTH-1:0]   ReqData = '0;
    logic               Clr = 1'b0;
    logic [WIDTH-1:0]   StkT, StkN;
    logic               StkTWrite, StkNWrite;
    logic [WIDTH-1:0]   StkWData;
    logic [1:0]         StkOffset;
    logic               StkRst, Done, Err, ErrUf, ErrOf;
    logic [DEPTH_W-1:0] Depth;

    always #5 Clk = ~Clk;

    stack_op_sequencer #(.WIDTH(WIDTH), .DEPTH(DEPTH), .DEPTH_W(DEPTH_W)) dut (
        .Clk(Clk), .Rst(Rst),
        .ReqValid_i(ReqValid), .ReqReady_o(ReqReady), .ReqOp_i(ReqOp), .ReqData_i(ReqData),
        .Clr_i(Clr), .StkT_i(StkT), .StkN_i(StkN),
        .StkTWrite_o(StkTWrite), .StkNWrite_o(StkNWrite), .StkWData_o(StkWData),
        .StkOffset_o(StkOffset), .StkRst_o(StkRst), .Done_o(Done), .Err_o(Err),
        .ErrUf_o(ErrUf), .ErrOf_o(ErrOf), .Depth_o(Depth)
    );

    int checks   = 0;
    int failures = 0;

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic int off_delta(input logic [1:0] o);
        if (o == 2'b01) return 1;
        if (o == 2'b11) return -1;
        return 0;
    endfunction

    // Data stack the DUT drives: top pointer sp, T at sp-1, N at sp-2
    logic [WIDTH-1:0] mem [0:511];
    int sp = 0;
    assign StkT = (sp >= 1) ? mem[sp-1] : '0;
    assign StkN = (sp >= 2) ? mem[sp-2] : '0;

    always @(posedge Clk) begin
        if (Rst || StkRst) begin
            sp <= 0;
        end else begin
            sp <= sp + off_delta(StkOffset);
            if (StkTWrite) mem[sp + off_delta(StkOffset) - 1] <= StkWData;
            if (StkNWrite) mem[sp + off_delta(StkOffset) - 2] <= StkWData;
        end
    end

    // Reference: Forth semantics on a queue plus the expected per-cycle step list
    typedef struct {
        logic [1:0]       off;
        bit               tw;
        bit               nw;
        logic [WIDTH-1:0] wd;
    } step_t;

    step_t            mq[$];
    logic [WIDTH-1:0] sem[$];
    int  m_depth = 0;
    bit  m_uf = 0, m_of = 0, m_err = 0, m_nopd = 0, m_clear = 0;

    task automatic add(input logic [1:0] off, input bit tw, input bit nw, input logic [WIDTH-1:0] wd);
        step_t s;
        s.off = off; s.tw = tw; s.nw = nw; s.wd = wd;
        mq.push_back(s);
    endtask

    task automatic model_accept(input logic [2:0] op, input logic [WIDTH-1:0] lit);
        int need;
        bit grows;
        logic [WIDTH-1:0] t, n;
        need  = (op == 1 || op == 2) ? 1 : (op >= 3 && op <= 6) ? 2 : 0;
        grows = (op == 1 || op == 4 || op == 6 || op == 7);
        t = (sem.size() >= 1) ? sem[sem.size()-1] : '0;
        n = (sem.size() >= 2) ? sem[sem.size()-2] : '0;
        if (m_depth < need) begin
            m_err = 1; m_uf = 1;
        end else if (grows && m_depth == DEPTH) begin
            m_err = 1; m_of = 1;
        end else begin
            case (op)
                3'd0: m_nopd = 1;
                3'd1: begin add(2'b01, 1, 0, t); sem.push_back(t); end
                3'd2: begin add(2'b11, 0, 0, '0); void'(sem.pop_back()); end
                3'd3: begin
                    add(2'b00, 1, 0, n); add(2'b00, 0, 1, t);
                    void'(sem.pop_back()); void'(sem.pop_back()); sem.push_back(t); sem.push_back(n);
                end
                3'd4: begin add(2'b01, 1, 0, n); sem.push_back(n); end
                3'd5: begin add(2'b11, 1, 0, t); void'(sem.pop_back()); void'(sem.pop_back()); sem.push_back(t); end
                3'd6: begin
                    add(2'b00, 0, 1, t); add(2'b01, 1, 0, n); add(2'b00, 1, 0, t); add(2'b00, 0, 1, n);
                    void'(sem.pop_back()); void'(sem.pop_back());
                    sem.push_back(t); sem.push_back(n); sem.push_back(t);
                end
                default: begin add(2'b01, 1, 0, lit); sem.push_back(lit); end
            endcase
        end
    endtask

    always @(negedge Clk) begin : compare
        step_t cur;
        bit    idle;
        int    bad;
        idle = !m_clear && (mq.size() == 0);
        if (mq.size() > 0) cur = mq[0];
        else begin cur.off = 2'b00; cur.tw = 0; cur.nw = 0; cur.wd = '0; end
        chk("ready",  ReqReady,  idle && !Clr && !Rst);
        chk("offset", StkOffset, cur.off);
        chk("twrite", StkTWrite, cur.tw);
        chk("nwrite", StkNWrite, cur.nw);
        chk("wdata",  StkWData,  cur.wd);
        chk("done",   Done,      (mq.size() == 1) || m_nopd);
        chk("err",    Err,       m_err);
        chk("stkrst", StkRst,    m_clear);
        chk("erruf",  ErrUf,     m_uf);
        chk("errof",  ErrOf,     m_of);
        chk("depth",  Depth,     m_depth);
        if (idle) begin
            bad = -1;
            for (int i = 0; i < sem.size(); i++)
                if (bad < 0 && mem[i] != sem[i]) bad = i;
            chk("stack_size", sp, sem.size());
            chk("stack_contents_first_bad", bad, -1);
        end
        if (Rst) begin
            mq.delete(); sem.delete();
            m_depth = 0; m_uf = 0; m_of = 0; m_err = 0; m_nopd = 0; m_clear = 0;
        end else begin
            m_err = 0; m_nopd = 0;
            if (mq.size() > 0) begin
                m_depth += off_delta(mq[0].off);
                void'(mq.pop_front());
            end
            if (Clr) begin
                mq.delete(); sem.delete();
                m_depth = 0; m_clear = 1;
            end else begin
                m_clear = 0;
                if (idle && ReqValid) model_accept(ReqOp, ReqData);
            end
        end
    end

    task automatic to_drive();
        @(posedge Clk); #1;
    endtask

    task automatic issue(input logic [2:0] op, input logic [WIDTH-1:0] d);
        ReqValid = 1'b1; ReqOp = op; ReqData = d;
        to_drive();
        ReqValid = 1'b0;
    endtask

    task automatic wait_ready();
        int n = 0;
        @(negedge Clk);
        while (!ReqReady && n < 40) begin
            @(negedge Clk);
            n++;
        end
        chk("ready_wait", ReqReady, 1);
        to_drive();
    endtask

    initial begin
        int lows;
        // reset state
        repeat (3) @(posedge Clk);
        @(negedge Clk);
        chk("rst_depth", Depth, 0);
        chk("rst_ready", ReqReady, 0);
        chk("rst_done", Done, 0);
        to_drive(); Rst = 1'b0;
        @(negedge Clk); chk("ready_after_rst", ReqReady, 1);
        to_drive();

        // two pushes
        issue(3'd7, 16'h1111);
        @(negedge Clk);
        chk("t1_off", StkOffset, 1); chk("t1_tw", StkTWrite, 1);
        chk("t1_wd", StkWData, 16'h1111); chk("t1_done", Done, 1);
        wait_ready();
        issue(3'd7, 16'h2222);
        @(negedge Clk); chk("t1_wd2", StkWData, 16'h2222);
        wait_ready();
        @(negedge Clk); chk("t1_depth", Depth, 2);
        to_drive();

        // SWAP
        issue(3'd3, '0);
        @(negedge Clk); chk("t2_s1_tw", StkTWrite, 1); chk("t2_s1_wd", StkWData, 16'h1111);
        @(negedge Clk); chk("t2_s2_nw", StkNWrite, 1); chk("t2_s2_wd", StkWData, 16'h2222);
        wait_ready();
        @(negedge Clk);
        chk("t2_T", StkT, 16'h1111); chk("t2_N", StkN, 16'h2222); chk("t2_depth", Depth, 2);
        to_drive();

        // SWAP back to (1111 2222), then TUCK
        issue(3'd3, '0);
        wait_ready();
        issue(3'd6, '0);
        lows = 0;
        @(negedge Clk);
        while (!ReqReady && lows < 10) begin
            lows++;
            @(negedge Clk);
        end
        chk("t3_busy_cycles", lows, 4);
        chk("t3_T", StkT, 16'h2222); chk("t3_N", StkN, 16'h1111);
        chk("t3_bottom", mem[0], 16'h2222); chk("t3_depth", Depth, 3);
        to_drive();

        // underflow: Depth=1 then SWAP
        Clr = 1'b1; to_drive(); Clr = 1'b0;
        wait_ready();
        issue(3'd7, 16'h4444);
        wait_ready();
        issue(3'd3, '0);
        @(negedge Clk);
        chk("t4_err", Err, 1); chk("t4_uf", ErrUf, 1); chk("t4_depth", Depth, 1);
        chk("t4_tw", StkTWrite, 0); chk("t4_ready", ReqReady, 1);
        to_drive();

        // overflow at Depth=256, then DROP
        for (int i = 0; i < DEPTH - 1; i++) begin
            issue(3'd7, WIDTH'($urandom));
            wait_ready();
        end
        @(negedge Clk); chk("t5_full", Depth, 256);
        to_drive();
        issue(3'd1, '0);
        @(negedge Clk); chk("t5_err", Err, 1); chk("t5_of", ErrOf, 1); chk("t5_depth", Depth, 256);
        to_drive();
        issue(3'd2, '0);
        @(negedge Clk); chk("t5_drop_off", StkOffset, 3);
        wait_ready();
        @(negedge Clk); chk("t5_depth_after", Depth, 255);
        to_drive();

        // Clr during TUCK S2
        Clr = 1'b1; to_drive(); Clr = 1'b0;
        wait_ready();
        issue(3'd7, 16'hAAAA); wait_ready();
        issue(3'd7, 16'hBBBB); wait_ready();
        issue(3'd6, '0);
        to_drive();
        Clr = 1'b1; to_drive(); Clr = 1'b0;
        @(negedge Clk); chk("t6_stkrst", StkRst, 1); chk("t6_done", Done, 0); chk("t6_depth", Depth, 0);
        wait_ready();
        issue(3'd2, '0);
        @(negedge Clk); chk("t6_err", Err, 1); chk("t6_uf", ErrUf, 1);
        to_drive();

        // randomized traffic
        for (int c = 0; c < 4000; c++) begin
            ReqValid = ($urandom_range(0, 9) < 7);
            ReqOp    = 3'($urandom_range(0, 7));
            ReqData  = WIDTH'($urandom);
            Clr      = ($urandom_range(0, 99) < 2);
            Rst      = ($urandom_range(0, 499) == 0);
            to_drive();
        end
        ReqValid = 1'b0; Clr = 1'b0; Rst = 1'b0;
        repeat (8) to_drive();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire
